// File: rtl/comp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_ctrl_pkg
// Description : Shared types for the running-maximum controller.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : comp_ctrl_pkg
`default_nettype wire

// File: rtl/comp_nbit_1cc.sv
`default_nettype none
// ============================================================================
// Module      : comp_nbit_1cc
// Description : Unsigned N-bit magnitude comparator. The output is 1 when
//               g_input >= e_input and 0 when g_input < e_input.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_nbit_1cc #(
   parameter int N = 8
) (
   input  logic [N-1:0] g_input,
   input  logic [N-1:0] e_input,
   output logic         g_ge_e
);

   assign g_ge_e = (g_input >= e_input);

endmodule : comp_nbit_1cc
`default_nettype wire

// File: rtl/comp_max_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : comp_max_ctrl
// Description : Collects K unsigned operands per run and reports the largest
//               value together with its earliest arrival index.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_max_ctrl
   import comp_ctrl_pkg::*;
#(
   parameter  int N  = 8,
   parameter  int K  = 4,
   localparam int IW = $clog2(K)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [N-1:0]  in_data,
   output logic          in_ready,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  max_out,
   output logic [IW-1:0] max_idx
);

   localparam logic [IW-1:0] c_last = IW'(K - 1);

   state_t          r_state;
   logic [IW-1:0]   r_cnt;
   logic [N-1:0]    r_run_max;
   logic [IW-1:0]   r_run_idx;
   logic [N-1:0]    r_max_out;
   logic [IW-1:0]   r_max_idx;
   logic            r_done;
   logic            r_busy;
   logic            r_in_ready;

   logic            w_accept;
   logic            w_first;
   logic            w_g_ge_e;
   logic            w_take;
   logic [N-1:0]    w_next_max;
   logic [IW-1:0]   w_next_idx;

   comp_nbit_1cc #(
      .N (N)
   ) u_cmp (
      .g_input (r_run_max),
      .e_input (in_data),
      .g_ge_e  (w_g_ge_e)
   );

   assign w_accept   = in_valid & r_in_ready;
   assign w_first    = (r_cnt == '0);
   // Strictly-greater replacement keeps the earliest index on ties.
   assign w_take     = w_first | ~w_g_ge_e;
   assign w_next_max = w_take ? in_data : r_run_max;
   assign w_next_idx = w_take ? r_cnt   : r_run_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_run_max  <= '0;
         r_run_idx  <= '0;
         r_max_out  <= '0;
         r_max_idx  <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state    <= ST_RUN;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_in_ready <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_accept) begin
                  r_run_max <= w_next_max;
                  r_run_idx <= w_next_idx;
                  if (r_cnt == c_last) begin
                     r_state    <= ST_DONE;
                     r_done     <= 1'b1;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b0;
                     r_max_out  <= w_next_max;
                     r_max_idx  <= w_next_idx;
                  end else begin
                     r_cnt <= r_cnt + IW'(1);
                  end
               end
            end
            ST_DONE: begin
               r_done <= 1'b0;
               // A start here chains straight into the next run.
               if (start) begin
                  r_state    <= ST_RUN;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_in_ready <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_done     <= 1'b0;
               r_busy     <= 1'b0;
               r_in_ready <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign busy     = r_busy;
   assign done     = r_done;
   assign max_out  = r_max_out;
   assign max_idx  = r_max_idx;

endmodule : comp_max_ctrl
`default_nettype wire

// File: tb/tb_comp_max_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_max_ctrl
// Description : Self-checking bench for comp_max_ctrl (N=8, K=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_max_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       busy;
   logic       done;
   logic [7:0] max_out;
   logic [1:0] max_idx;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_max = 8'h00;
   logic [1:0] exp_idx = 2'd0;
   logic       ready_ok;
   logic       hold_ok;

   comp_max_ctrl #(.N(8), .K(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .busy     (busy),
      .done     (done),
      .max_out  (max_out),
      .max_idx  (max_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: largest value, then the first position holding it.
   function automatic void ref_model(input logic [7:0] ops [4],
                                     output logic [7:0] m, output logic [1:0] ix);
      int best;
      best = 0;
      foreach (ops[i]) if (int'(ops[i]) > best) best = int'(ops[i]);
      m  = 8'(best);
      ix = 2'd0;
      for (int i = 3; i >= 0; i--) if (int'(ops[i]) == best) ix = 2'(i);
   endfunction

   // Issues start at the current negedge, then K beats with idle gaps.
   // Returns at the negedge of the DONE cycle with in_valid low.
   task automatic do_run(input logic [7:0] ops [4], input int gap,
                         input logic [7:0] pmax, input logic [1:0] pidx);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      ready_ok = 1'b1;
      hold_ok  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g <= gap; g++) begin
            if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) ready_ok = 1'b0;
            if (max_out !== pmax || max_idx !== pidx) hold_ok = 1'b0;
            if (g < gap) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               @(negedge clk);
            end
         end
         in_valid = 1'b1;
         in_data  = ops[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic test_reset();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
          max_out !== 8'h00 || max_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_state: done=%b busy=%b rdy=%b max=%h idx=%0d, want 0 0 0 00 0",
                  done, busy, in_ready, max_out, max_idx);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_wait: busy=%b rdy=%b, want 0 0", busy, in_ready);
      end
   endtask

   task automatic test_directed(input string name, input logic [7:0] ops [4], input int gap);
      logic [7:0] m;
      logic [1:0] ix;
      ref_model(ops, m, ix);
      do_run(ops, gap, exp_max, exp_idx);
      checks++;
      if (done !== 1'b1 || max_out !== m || max_idx !== ix) begin
         errors++;
         $display("FAIL %s result: done=%b max=%h idx=%0d, want 1 %h %0d",
                  name, done, max_out, max_idx, m, ix);
      end
      checks++;
      if (ready_ok !== 1'b1 || hold_ok !== 1'b1) begin
         errors++;
         $display("FAIL %s run_flags: ready_ok=%b hold_ok=%b, want 1 1", name, ready_ok, hold_ok);
      end
      exp_max = m;
      exp_idx = ix;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || max_out !== m || max_idx !== ix) begin
         errors++;
         $display("FAIL %s after_done: done=%b busy=%b max=%h idx=%0d, want 0 0 %h %0d",
                  name, done, busy, max_out, max_idx, m, ix);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ops [4];
      ops = '{8'h00, 8'h00, 8'h00, 8'h00};
      do_run(ops, 0, exp_max, exp_idx);
      checks++;
      if (done !== 1'b1 || max_out !== 8'h00 || max_idx !== 2'd0) begin
         errors++;
         $display("FAIL b2b_run1: done=%b max=%h idx=%0d, want 1 00 0", done, max_out, max_idx);
      end
      ops = '{8'h05, 8'h80, 8'h7F, 8'h80};
      do_run(ops, 0, 8'h00, 2'd0);
      checks++;
      if (done !== 1'b1 || max_out !== 8'h80 || max_idx !== 2'd1 || ready_ok !== 1'b1) begin
         errors++;
         $display("FAIL b2b_run2: done=%b max=%h idx=%0d ready_ok=%b, want 1 80 1 1",
                  done, max_out, max_idx, ready_ok);
      end
      exp_max = 8'h80;
      exp_idx = 2'd1;
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      logic [7:0] ops [4];
      logic       saw_done;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hF0 + 8'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
          max_out !== 8'h00 || max_idx !== 2'd0) begin
         errors++;
         $display("FAIL abort_async: done=%b busy=%b rdy=%b max=%h idx=%0d, want 0 0 0 00 0",
                  done, busy, in_ready, max_out, max_idx);
      end
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_data  = 8'hEE;
         if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (saw_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: activity after reset=%b, want 0", saw_done);
      end
      exp_max = 8'h00;
      exp_idx = 2'd0;
      ops = '{8'h33, 8'h44, 8'h22, 8'h11};
      test_directed("after_abort", ops, 0);
   endtask

   task automatic test_idle_valid();
      logic [7:0] ops [4];
      for (int c = 0; c < 2; c++) begin
         in_valid = 1'b1;
         in_data  = 8'hC3;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: in_ready=%b, want 0", in_ready);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      ops = '{8'h10, 8'h20, 8'h30, 8'h40};
      test_directed("idle_valid", ops, 0);
   endtask

   task automatic test_random();
      logic [7:0] ops [4];
      logic [7:0] m;
      logic [1:0] ix;
      int         gap;
      for (int r = 0; r < 40; r++) begin
         foreach (ops[i])
            ops[i] = (r % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3) * 64 + 63);
         gap = $urandom_range(0, 2);
         ref_model(ops, m, ix);
         do_run(ops, gap, exp_max, exp_idx);
         checks++;
         if (done !== 1'b1 || max_out !== m || max_idx !== ix ||
             ready_ok !== 1'b1 || hold_ok !== 1'b1) begin
            errors++;
            $display("FAIL random_%0d: done=%b max=%h idx=%0d rdy_ok=%b hold_ok=%b, want 1 %h %0d 1 1",
                     r, done, max_out, max_idx, ready_ok, hold_ok, m, ix);
         end
         exp_max = m;
         exp_idx = ix;
         if ($urandom_range(0, 1) == 0) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || max_out !== m || max_idx !== ix) begin
               errors++;
               $display("FAIL random_hold_%0d: done=%b busy=%b max=%h idx=%0d, want 0 0 %h %0d",
                        r, done, busy, max_out, max_idx, m, ix);
            end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] ops [4];
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #1;
      test_reset();
      ops = '{8'hA9, 8'h7B, 8'hFD, 8'h74};
      test_directed("basic", ops, 0);
      ops = '{8'hAA, 8'hAA, 8'h10, 8'hAA};
      test_directed("tie", ops, 0);
      ops = '{8'h01, 8'h02, 8'h03, 8'hFF};
      test_directed("gaps", ops, 2);
      test_back_to_back();
      test_reset_abort();
      test_idle_valid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_comp_max_ctrl
`default_nettype wire
